ahb_bram_arbiter_2to1: RTL and testbench
========================================

# ahb_bram_arbiter_2to1

Two-port AHB-Lite arbiter that lets two masters share one single-port AHB block RAM slave. Port S0 is typically the processor bus and S1 a DMA or debug bus. Each port's address phase is forwarded to the RAM with zero added latency when uncontested. On a same-cycle conflict the loser's address phase is held, and the loser sees exactly one wait state per conflict. The block sits between the two bus decoders/muxes and the block RAM's AHB slave port.

## Interface
- ADDRESSWIDTH, 12: byte-address width of all HADDR buses.
- HCLK  in  1  system bus clock.
- HRESETn  in  1  system bus reset. One clock; reset is asynchronous and active-low.
- HSELS0/HSELS1  in  1  port select.
- HREADYS0/HREADYS1  in  1  bus HREADY of each port's bus.
- HTRANSS0/1  in  2  transfer type.
- HSIZES0/1  in  2  transfer size.
- HWRITES0/1  in  1  write flag.
- HADDRS0/1  in  ADDRESSWIDTH  address.
- HWDATAS0/1  in  32  write data.
- HREADYOUTS0/1  out  1  per-port ready.
- HRESPS0/1  out  1  per-port response.
- HRDATAS0/1  out  32  per-port read data.
- HSELM, HTRANSM, HSIZEM, HWRITEM, HADDRM, HWDATAM  out  1/2/2/1/ADDRESSWIDTH/32  RAM-side request.
- HREADYM  out  1  RAM-side HREADY; equals HREADYOUTM.
- HREADYOUTM  in  1  RAM ready.
- HRESPM  in  1  RAM response.
- HRDATAM  in  32  RAM read data.

## Operation
- Port request: valid_x = HSELSx & HREADYSx & HTRANSSx[1]. IDLE and BUSY transfers are never forwarded.
- Per-port state machine:
  - IDLE -> DATA when valid_x and granted this cycle.
  - IDLE -> PEND when valid_x and not granted; the address-phase signals are captured into a hold register.
  - PEND -> DATA when granted.
  - DATA -> IDLE on HREADYOUTM=1 with no new valid_x.
  - DATA -> DATA on HREADYOUTM=1 with a new valid_x that is granted.
  - DATA -> PEND on HREADYOUTM=1 with a new valid_x that is not granted.
- Master address slot is free when HREADYOUTM=1.
- Candidates in a free slot:
  - a PEND port, using its hold register;
  - a port with live valid_x, using its live bus signals.
- Arbitration:
  - A PEND port beats a live request from the other port.
  - Two live requests resolve round-robin via last_grant; the winner is recorded.
  - Only one port can be PEND at a time by construction.
- No candidate: HSELM=0, HTRANSM=IDLE, other master outputs are don't-care (drive from S0 live).
- owner register (NONE/S0/S1) updates on HREADYOUTM=1 to the granted port, or NONE if there is no grant.
- HWDATAM = HWDATAS[owner]. The write data needs no buffering because the loser's data phase is stretched, so its bus holds HWDATA stable.
- HRDATASx = HRDATAM for both ports.
- HRESPSx = HRESPM when owner=x, else OKAY.
- HREADYOUTSx:
  - 0 in PEND;
  - HREADYOUTM in DATA with owner=x;
  - 1 otherwise.
- Width rules: HSIZE and HADDR pass through unmodified. Byte-lane decode stays in the RAM.

## Timing
- Reset values:
  - all HREADYOUTSx=1 and HRESPSx=0;
  - HSELM=0, HTRANSM=IDLE;
  - owner=NONE, both ports IDLE, hold registers 0;
  - last_grant=S1, so S0 wins the first conflict.
- Uncontested: the address passes combinationally in the same cycle. Read data is returned in the next cycle with HREADYOUTSx=1, i.e. zero waits.
- Conflict in cycle T:
  - winner is forwarded in T;
  - loser goes to PEND with HREADYOUTS=0 in T+1 while its held address is forwarded;
  - loser data completes in T+2.
- Back-to-back simultaneous streams alternate grants, giving each port ~50% throughput.
- RAM wait states (HREADYOUTM=0) freeze arbitration and state. The owner's HREADYOUT follows HREADYOUTM.
- Reset mid-operation: everything returns asynchronously to reset values. Any PEND transfer is dropped.

## Structure
- Shared package holds:
  - HTRANS encodings (TRN_IDLE/BUSY/NONSEQ/SEQ);
  - HRESP codes (RSP_OKAY/ERROR);
  - owner encoding (OWN_NONE/S0/S1);
  - port-state encoding (ST_IDLE/PEND/DATA).
- Sub-module ahb_bram_arb_port holds the per-port state machine, hold register, and live/held request mux. It is instantiated twice.
- Top level contains the arbiter, last_grant, owner and the master-side muxing.

## Test plan
- S0 read 0x004 alone after RAM preloaded with 0x11223344 -> HTRANSM=NONSEQ same cycle; HRDATAS0=0x11223344 next cycle; zero waits.
- First-cycle conflict after reset, S0 write word 0x004=0xDEADBEEF and S1 read 0x004 -> S0 forwarded first; HREADYOUTS1=0 for one cycle; S1 reads 0xDEADBEEF.
- Both ports issue 4 consecutive NONSEQ reads -> grants alternate S0,S1,S0,S1…; each port sees one wait per conflict.
- S1 byte write HSIZE=0, addr 0x011, data 0x00AB0000 while S0 idle -> only the byte lane at 0x011 changes; neighbour bytes are unchanged on readback.
- S1 in PEND when HRESETn is pulsed low -> HREADYOUTS1=1 and HTRANSM=IDLE immediately; the held write never reaches the RAM.
- S0 sequential burst interleaved with S0 BUSY cycles while S1 idle -> BUSY is never forwarded (HTRANSM=IDLE); all data is correct with zero waits.

Source files
------------

// File: rtl/ahb_bram_arbiter_2to1_pkg.sv
// Shared encodings for the 2:1 AHB-Lite block RAM arbiter.
package ahb_bram_arbiter_2to1_pkg;

   localparam logic [1:0] TRN_IDLE   = 2'b00;
   localparam logic [1:0] TRN_BUSY   = 2'b01;
   localparam logic [1:0] TRN_NONSEQ = 2'b10;
   localparam logic [1:0] TRN_SEQ    = 2'b11;

   localparam logic RSP_OKAY  = 1'b0;
   localparam logic RSP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_S0   = 2'd1,
      OWN_S1   = 2'd2
   } owner_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PEND = 2'd1,
      ST_DATA = 2'd2
   } port_state_t;

   // Address-phase control fields held for a pended request
   typedef struct packed {
      logic [1:0] trans;
      logic [1:0] size;
      logic       write;
   } ctrl_t;

endpackage

// File: rtl/ahb_bram_arb_port.sv
// Per-port slave front end: tracks address/data phase, holds a losing
// address phase and presents either the live or the held request.
module ahb_bram_arb_port
   import ahb_bram_arbiter_2to1_pkg::*;
#(
   parameter int unsigned ADDRESSWIDTH = 12
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    sel,
   input  logic                    ready,
   input  logic [1:0]              trans,
   input  logic [1:0]              size,
   input  logic                    write,
   input  logic [ADDRESSWIDTH-1:0] addr,
   input  logic                    slot_free,
   input  logic                    grant,
   input  logic                    owned,
   output logic                    req_c,
   output logic                    pend_c,
   output ctrl_t                   req_ctrl_c,
   output logic [ADDRESSWIDTH-1:0] req_addr_c,
   output logic                    ready_out_c
);

   port_state_t             state;
   port_state_t             state_nxt;
   logic                    capture;
   logic                    valid;
   ctrl_t                   live_ctrl;
   ctrl_t                   hold_ctrl;
   logic [ADDRESSWIDTH-1:0] hold_addr;

   assign valid      = sel & ready & trans[1];
   assign live_ctrl  = '{trans: trans, size: size, write: write};
   assign pend_c     = (state == ST_PEND);
   assign req_c      = pend_c | valid;
   assign req_ctrl_c = pend_c ? hold_ctrl : live_ctrl;
   assign req_addr_c = pend_c ? hold_addr : addr;

   // A pended port stalls its bus; the owner follows the RAM's ready
   assign ready_out_c = pend_c ? 1'b0 :
                        ((state == ST_DATA) && owned) ? slot_free : 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (valid) begin
               if (grant) begin
                  state_nxt = ST_DATA;
               end else begin
                  state_nxt = ST_PEND;
                  capture   = 1'b1;
               end
            end
         end
         ST_PEND: begin
            if (grant) state_nxt = ST_DATA;
         end
         ST_DATA: begin
            if (slot_free) begin
               if (!valid) begin
                  state_nxt = ST_IDLE;
               end else if (grant) begin
                  state_nxt = ST_DATA;
               end else begin
                  state_nxt = ST_PEND;
                  capture   = 1'b1;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_ctrl <= '0;
         hold_addr <= '0;
      end else if (capture) begin
         hold_ctrl <= live_ctrl;
         hold_addr <= addr;
      end
   end

endmodule

// File: rtl/ahb_bram_arbiter_2to1.sv
// Two AHB-Lite masters sharing one single-port block RAM slave; zero-latency
// forwarding when uncontested, one wait state for the loser of a conflict.
module ahb_bram_arbiter_2to1
   import ahb_bram_arbiter_2to1_pkg::*;
#(
   parameter int unsigned ADDRESSWIDTH = 12
) (
   input  logic                    HCLK,
   input  logic                    HRESETn,
   input  logic                    HSELS0,
   input  logic                    HREADYS0,
   input  logic [1:0]              HTRANSS0,
   input  logic [1:0]              HSIZES0,
   input  logic                    HWRITES0,
   input  logic [ADDRESSWIDTH-1:0] HADDRS0,
   input  logic [31:0]             HWDATAS0,
   output logic                    HREADYOUTS0,
   output logic                    HRESPS0,
   output logic [31:0]             HRDATAS0,
   input  logic                    HSELS1,
   input  logic                    HREADYS1,
   input  logic [1:0]              HTRANSS1,
   input  logic [1:0]              HSIZES1,
   input  logic                    HWRITES1,
   input  logic [ADDRESSWIDTH-1:0] HADDRS1,
   input  logic [31:0]             HWDATAS1,
   output logic                    HREADYOUTS1,
   output logic                    HRESPS1,
   output logic [31:0]             HRDATAS1,
   output logic                    HSELM,
   output logic [1:0]              HTRANSM,
   output logic [1:0]              HSIZEM,
   output logic                    HWRITEM,
   output logic [ADDRESSWIDTH-1:0] HADDRM,
   output logic [31:0]             HWDATAM,
   output logic                    HREADYM,
   input  logic                    HREADYOUTM,
   input  logic                    HRESPM,
   input  logic [31:0]             HRDATAM
);

   logic                    req0, req1;
   logic                    pend0, pend1;
   ctrl_t                   ctrl0, ctrl1;
   logic [ADDRESSWIDTH-1:0] addr0, addr1;
   logic                    grant0_c, grant1_c;
   owner_t                  owner;
   owner_t                  last_grant;

   ahb_bram_arb_port #(.ADDRESSWIDTH(ADDRESSWIDTH)) u_port0 (
      .clk         (HCLK),
      .rst_n       (HRESETn),
      .sel         (HSELS0),
      .ready       (HREADYS0),
      .trans       (HTRANSS0),
      .size        (HSIZES0),
      .write       (HWRITES0),
      .addr        (HADDRS0),
      .slot_free   (HREADYOUTM),
      .grant       (grant0_c),
      .owned       (owner == OWN_S0),
      .req_c       (req0),
      .pend_c      (pend0),
      .req_ctrl_c  (ctrl0),
      .req_addr_c  (addr0),
      .ready_out_c (HREADYOUTS0)
   );

   ahb_bram_arb_port #(.ADDRESSWIDTH(ADDRESSWIDTH)) u_port1 (
      .clk         (HCLK),
      .rst_n       (HRESETn),
      .sel         (HSELS1),
      .ready       (HREADYS1),
      .trans       (HTRANSS1),
      .size        (HSIZES1),
      .write       (HWRITES1),
      .addr        (HADDRS1),
      .slot_free   (HREADYOUTM),
      .grant       (grant1_c),
      .owned       (owner == OWN_S1),
      .req_c       (req1),
      .pend_c      (pend1),
      .req_ctrl_c  (ctrl1),
      .req_addr_c  (addr1),
      .ready_out_c (HREADYOUTS1)
   );

   // Pended request first, then round-robin between two live requests
   always_comb begin
      grant0_c = 1'b0;
      grant1_c = 1'b0;
      if (HREADYOUTM) begin
         if (pend0)              grant0_c = 1'b1;
         else if (pend1)         grant1_c = 1'b1;
         else if (req0 && req1) begin
            if (last_grant == OWN_S1) grant0_c = 1'b1;
            else                      grant1_c = 1'b1;
         end
         else if (req0)          grant0_c = 1'b1;
         else if (req1)          grant1_c = 1'b1;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         owner      <= OWN_NONE;
         last_grant <= OWN_S1;
      end else if (HREADYOUTM) begin
         owner <= grant0_c ? OWN_S0 : (grant1_c ? OWN_S1 : OWN_NONE);
         if (grant0_c)      last_grant <= OWN_S0;
         else if (grant1_c) last_grant <= OWN_S1;
      end
   end

   always_comb begin
      HSELM   = grant0_c | grant1_c;
      HTRANSM = TRN_IDLE;
      HSIZEM  = HSIZES0;
      HWRITEM = HWRITES0;
      HADDRM  = HADDRS0;
      if (grant1_c) begin
         HTRANSM = ctrl1.trans;
         HSIZEM  = ctrl1.size;
         HWRITEM = ctrl1.write;
         HADDRM  = addr1;
      end else if (grant0_c) begin
         HTRANSM = ctrl0.trans;
         HSIZEM  = ctrl0.size;
         HWRITEM = ctrl0.write;
         HADDRM  = addr0;
      end
   end

   // The losing master's data phase is stretched, so its HWDATA is still valid
   assign HWDATAM  = (owner == OWN_S1) ? HWDATAS1 : HWDATAS0;
   assign HREADYM  = HREADYOUTM;
   assign HRDATAS0 = HRDATAM;
   assign HRDATAS1 = HRDATAM;
   assign HRESPS0  = (owner == OWN_S0) ? HRESPM : RSP_OKAY;
   assign HRESPS1  = (owner == OWN_S1) ? HRESPM : RSP_OKAY;

endmodule

// File: tb/tb_ahb_bram_arbiter_2to1.sv
// Self-checking bench: two AHB master models, a behavioural RAM slave and a
// read-data scoreboard per port.
module tb_ahb_bram_arbiter_2to1;
   import ahb_bram_arbiter_2to1_pkg::*;

   localparam int unsigned AW = 12;

   typedef struct packed {
      logic [1:0]    trans;
      logic          write;
      logic [1:0]    size;
      logic [AW-1:0] addr;
      logic [31:0]   wdata;
      logic [31:0]   exp;
   } cmd_t;

   typedef struct packed {
      logic [31:0]   cyc;
      logic [AW-1:0] addr;
      logic [1:0]    trans;
      logic [1:0]    size;
      logic          write;
   } fwd_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          hsel_s0, hsel_s1, hwrite_s0, hwrite_s1;
   logic [1:0]    htrans_s0, htrans_s1, hsize_s0, hsize_s1;
   logic [AW-1:0] haddr_s0, haddr_s1;
   logic [31:0]   hwdata_s0, hwdata_s1, hrdata_s0, hrdata_s1;
   logic          hready_s0, hready_s1, hreadyout_s0, hreadyout_s1;
   logic          hresp_s0, hresp_s1;
   logic          hsel_m, hwrite_m, hready_m, hreadyout_m, hresp_m;
   logic [1:0]    htrans_m, hsize_m;
   logic [AW-1:0] haddr_m;
   logic [31:0]   hwdata_m, hrdata_m;

   always #5 clk = ~clk;

   assign hready_s0 = hreadyout_s0;
   assign hready_s1 = hreadyout_s1;

   ahb_bram_arbiter_2to1 #(.ADDRESSWIDTH(AW)) dut (
      .HCLK(clk), .HRESETn(rst_n),
      .HSELS0(hsel_s0), .HREADYS0(hready_s0), .HTRANSS0(htrans_s0), .HSIZES0(hsize_s0),
      .HWRITES0(hwrite_s0), .HADDRS0(haddr_s0), .HWDATAS0(hwdata_s0),
      .HREADYOUTS0(hreadyout_s0), .HRESPS0(hresp_s0), .HRDATAS0(hrdata_s0),
      .HSELS1(hsel_s1), .HREADYS1(hready_s1), .HTRANSS1(htrans_s1), .HSIZES1(hsize_s1),
      .HWRITES1(hwrite_s1), .HADDRS1(haddr_s1), .HWDATAS1(hwdata_s1),
      .HREADYOUTS1(hreadyout_s1), .HRESPS1(hresp_s1), .HRDATAS1(hrdata_s1),
      .HSELM(hsel_m), .HTRANSM(htrans_m), .HSIZEM(hsize_m), .HWRITEM(hwrite_m),
      .HADDRM(haddr_m), .HWDATAM(hwdata_m), .HREADYM(hready_m),
      .HREADYOUTM(hreadyout_m), .HRESPM(hresp_m), .HRDATAM(hrdata_m)
   );

   // Behavioural zero-wait RAM slave, little-endian byte lanes
   logic [31:0]   mem [0:1023];
   logic          pl_en;
   logic [9:0]    pl_idx;
   logic [31:0]   pl_data;
   logic          ram_v, ram_w;
   logic [1:0]    ram_sz;
   logic [AW-1:0] ram_a;
   logic [3:0]    ram_lanes;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ram_v <= 1'b0; ram_w <= 1'b0; ram_sz <= '0; ram_a <= '0;
      end else if (hready_m) begin
         ram_v <= hsel_m & htrans_m[1]; ram_w <= hwrite_m; ram_sz <= hsize_m; ram_a <= haddr_m;
      end
   end

   always_comb begin
      case (ram_sz)
         2'd0:    ram_lanes = 4'b0001 << ram_a[1:0];
         2'd1:    ram_lanes = ram_a[1] ? 4'b1100 : 4'b0011;
         default: ram_lanes = 4'b1111;
      endcase
   end

   always_ff @(posedge clk) begin
      if (pl_en) mem[pl_idx] <= pl_data;
      else if (rst_n && hready_m && ram_v && ram_w)
         for (int b = 0; b < 4; b++)
            if (ram_lanes[b]) mem[ram_a[11:2]][8*b +: 8] <= hwdata_m[8*b +: 8];
   end

   assign hrdata_m = mem[ram_a[11:2]];
   assign hresp_m  = RSP_OKAY;

   // Master models and bookkeeping
   int          n_tests = 0;
   int          n_fail  = 0;
   int unsigned cyc     = 0;
   cmd_t        cq0[$], cq1[$];
   logic [31:0] sb0[$], sb1[$];
   fwd_t        fwd[$];
   cmd_t        cur[2], dpc[2];
   logic        cur_v[2], dpv[2], rdy_s[2];
   logic [31:0] rdata_s[2];
   int          waits[2];
   int unsigned issue_cyc[2];

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic drive();
      hsel_s0   = cur_v[0];
      htrans_s0 = cur_v[0] ? cur[0].trans : TRN_IDLE;
      hsize_s0  = cur[0].size;
      hwrite_s0 = cur[0].write;
      haddr_s0  = cur[0].addr;
      hwdata_s0 = dpv[0] ? dpc[0].wdata : 32'h0;
      hsel_s1   = cur_v[1];
      htrans_s1 = cur_v[1] ? cur[1].trans : TRN_IDLE;
      hsize_s1  = cur[1].size;
      hwrite_s1 = cur[1].write;
      haddr_s1  = cur[1].addr;
      hwdata_s1 = dpv[1] ? dpc[1].wdata : 32'h0;
   endtask

   task automatic master_step(input int p);
      cmd_t        nc;
      logic        have;
      logic [31:0] exp;
      if (!rdy_s[p]) return;
      if (dpv[p] && !dpc[p].write) begin
         exp = 'x;
         if (p == 0 && sb0.size() != 0) exp = sb0.pop_front();
         if (p == 1 && sb1.size() != 0) exp = sb1.pop_front();
         check_eq(p == 0 ? "rdata_s0" : "rdata_s1", rdata_s[p], exp);
      end
      dpv[p] = cur_v[p] && cur[p].trans[1];
      dpc[p] = cur[p];
      have = 1'b0;
      nc   = '0;
      if (p == 0 && cq0.size() != 0) begin nc = cq0.pop_front(); have = 1'b1; end
      if (p == 1 && cq1.size() != 0) begin nc = cq1.pop_front(); have = 1'b1; end
      cur_v[p] = have;
      if (have) begin
         cur[p]       = nc;
         issue_cyc[p] = cyc;
         if (nc.trans[1] && !nc.write) begin
            if (p == 0) sb0.push_back(nc.exp);
            else        sb1.push_back(nc.exp);
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      rdy_s[0] = hreadyout_s0; rdy_s[1] = hreadyout_s1;
      rdata_s[0] = hrdata_s0;  rdata_s[1] = hrdata_s1;
      for (int p = 0; p < 2; p++)
         if ((cur_v[p] || dpv[p]) && !rdy_s[p]) waits[p]++;
      if (hsel_m && htrans_m[1] && hready_m)
         fwd.push_back('{cyc: cyc, addr: haddr_m, trans: htrans_m, size: hsize_m, write: hwrite_m});
      if (cur_v[0] && cur[0].trans == TRN_BUSY && !cur_v[1] && !dpv[1])
         check_eq("busy_fwd", 32'(htrans_m), 32'(TRN_IDLE));
      @(posedge clk);
      cyc++;
      #1;
      master_step(0);
      master_step(1);
      drive();
   endtask

   task automatic run(input int max_cycles);
      int   n;
      logic busy;
      n = 0;
      busy = 1'b1;
      while (busy && n < max_cycles) begin
         tick();
         n++;
         busy = (cq0.size() != 0) || (cq1.size() != 0) || cur_v[0] || cur_v[1] || dpv[0] || dpv[1];
      end
      check_eq("run_done", 32'(busy), 32'd0);
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      cq0.delete(); cq1.delete(); sb0.delete(); sb1.delete(); fwd.delete();
      for (int p = 0; p < 2; p++) begin
         cur[p] = '0; dpc[p] = '0; cur_v[p] = 1'b0; dpv[p] = 1'b0;
         waits[p] = 0; issue_cyc[p] = 0;
      end
      drive();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic preload(input int idx, input logic [31:0] data);
      @(negedge clk);
      pl_en = 1'b1; pl_idx = 10'(idx); pl_data = data;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   function automatic cmd_t mk(input logic [1:0] tr, input logic wr, input logic [1:0] sz,
                               input logic [AW-1:0] a, input logic [31:0] wd, input logic [31:0] ex);
      return '{trans: tr, write: wr, size: sz, addr: a, wdata: wd, exp: ex};
   endfunction

   initial begin
      rst_n = 1'b0; pl_en = 1'b0; pl_idx = '0; pl_data = '0; hreadyout_m = 1'b1;
      for (int p = 0; p < 2; p++) begin cur[p] = '0; dpc[p] = '0; cur_v[p] = 1'b0; dpv[p] = 1'b0; end
      drive();
      #1;
      check_eq("rst_readyout_s0", 32'(hreadyout_s0), 32'd1);
      check_eq("rst_readyout_s1", 32'(hreadyout_s1), 32'd1);
      check_eq("rst_resp_s0",     32'(hresp_s0),     32'(RSP_OKAY));
      check_eq("rst_resp_s1",     32'(hresp_s1),     32'(RSP_OKAY));
      check_eq("rst_hselm",       32'(hsel_m),       32'd0);
      check_eq("rst_htransm",     32'(htrans_m),     32'(TRN_IDLE));

      // Lone S0 read: forwarded in its own cycle, zero waits
      preload(1, 32'h1122_3344);
      reset_dut();
      cq0.push_back(mk(TRN_NONSEQ, 1'b0, 2'd2, 12'h004, 32'h0, 32'h1122_3344));
      run(20);
      check_eq("t1_waits", 32'(waits[0]), 32'd0);
      check_eq("t1_nfwd", 32'(fwd.size()), 32'd1);
      if (fwd.size() >= 1) begin
         check_eq("t1_addr",  32'(fwd[0].addr),  32'h004);
         check_eq("t1_trans", 32'(fwd[0].trans), 32'(TRN_NONSEQ));
         check_eq("t1_cyc",   fwd[0].cyc,        32'(issue_cyc[0]));
      end

      // First conflict after reset: S0 wins, S1 pends for one cycle
      reset_dut();
      cq0.push_back(mk(TRN_NONSEQ, 1'b1, 2'd2, 12'h004, 32'hDEAD_BEEF, 32'h0));
      cq1.push_back(mk(TRN_NONSEQ, 1'b0, 2'd2, 12'h004, 32'h0, 32'hDEAD_BEEF));
      run(20);
      check_eq("t2_waits_s0", 32'(waits[0]), 32'd0);
      check_eq("t2_waits_s1", 32'(waits[1]), 32'd1);
      check_eq("t2_nfwd", 32'(fwd.size()), 32'd2);
      if (fwd.size() >= 2) begin
         check_eq("t2_first_write", 32'(fwd[0].write), 32'd1);
         check_eq("t2_second_read", 32'(fwd[1].write), 32'd0);
         check_eq("t2_pend_cyc",    fwd[1].cyc,        fwd[0].cyc + 32'd1);
      end

      // Simultaneous streams alternate grants
      for (int i = 0; i < 4; i++) begin
         preload(32'h40 + i, 32'hA000_0000 + 32'(i));
         preload(32'h80 + i, 32'hB000_0000 + 32'(i));
      end
      reset_dut();
      for (int i = 0; i < 4; i++) begin
         cq0.push_back(mk(TRN_NONSEQ, 1'b0, 2'd2, 12'(12'h100 + 4*i), 32'h0, 32'hA000_0000 + 32'(i)));
         cq1.push_back(mk(TRN_NONSEQ, 1'b0, 2'd2, 12'(12'h200 + 4*i), 32'h0, 32'hB000_0000 + 32'(i)));
      end
      run(40);
      check_eq("t3_nfwd", 32'(fwd.size()), 32'd8);
      for (int i = 0; i < 8 && i < fwd.size(); i++)
         check_eq("t3_grant_order", 32'(fwd[i].addr[9:8]), (i % 2 == 0) ? 32'd1 : 32'd2);
      check_eq("t3_waits_s0", 32'(waits[0]), 32'd3);
      check_eq("t3_waits_s1", 32'(waits[1]), 32'd4);

      // S1 byte write at 0x011: lane 1 takes bits [15:8] of HWDATA, others untouched
      preload(4, 32'h4433_2211);
      reset_dut();
      cq1.push_back(mk(TRN_NONSEQ, 1'b1, 2'd0, 12'h011, 32'h00AB_0000, 32'h0));
      cq1.push_back(mk(TRN_NONSEQ, 1'b0, 2'd2, 12'h010, 32'h0, 32'h4433_0011));
      run(20);
      check_eq("t4_waits", 32'(waits[1]), 32'd0);
      if (fwd.size() >= 1) begin
         check_eq("t4_size", 32'(fwd[0].size), 32'd0);
         check_eq("t4_addr", 32'(fwd[0].addr), 32'h011);
      end

      // Burst with BUSY cycles: BUSY never forwarded, zero waits
      for (int i = 0; i < 4; i++) preload(32'h10 + i, 32'hC0DE_0000 + 32'(i));
      reset_dut();
      cq0.push_back(mk(TRN_NONSEQ, 1'b0, 2'd2, 12'h040, 32'h0, 32'hC0DE_0000));
      cq0.push_back(mk(TRN_BUSY,   1'b0, 2'd2, 12'h044, 32'h0, 32'h0));
      cq0.push_back(mk(TRN_SEQ,    1'b0, 2'd2, 12'h044, 32'h0, 32'hC0DE_0001));
      cq0.push_back(mk(TRN_BUSY,   1'b0, 2'd2, 12'h048, 32'h0, 32'h0));
      cq0.push_back(mk(TRN_SEQ,    1'b0, 2'd2, 12'h048, 32'h0, 32'hC0DE_0002));
      cq0.push_back(mk(TRN_SEQ,    1'b0, 2'd2, 12'h04C, 32'h0, 32'hC0DE_0003));
      run(30);
      check_eq("t6_waits", 32'(waits[0]), 32'd0);
      check_eq("t6_nfwd",  32'(fwd.size()), 32'd4);

      // Reset while S1 is pended: held write must be dropped
      preload(9, 32'h5555_5555);
      reset_dut();
      hsel_s0 = 1'b1; htrans_s0 = TRN_NONSEQ; hsize_s0 = 2'd2; hwrite_s0 = 1'b0; haddr_s0 = 12'h020;
      hsel_s1 = 1'b1; htrans_s1 = TRN_NONSEQ; hsize_s1 = 2'd2; hwrite_s1 = 1'b1; haddr_s1 = 12'h024;
      @(negedge clk);
      check_eq("t5_s0_first", 32'(haddr_m), 32'h020);
      @(posedge clk);
      #1;
      hsel_s0 = 1'b0; htrans_s0 = TRN_IDLE; hsel_s1 = 1'b0; htrans_s1 = TRN_IDLE;
      hwdata_s1 = 32'hCAFE_F00D;
      #1;
      check_eq("t5_pend_ready", 32'(hreadyout_s1), 32'd0);
      check_eq("t5_pend_fwd",   32'(htrans_m),     32'(TRN_NONSEQ));
      check_eq("t5_pend_addr",  32'(haddr_m),      32'h024);
      rst_n = 1'b0;
      #1;
      check_eq("t5_rst_ready",  32'(hreadyout_s1), 32'd1);
      check_eq("t5_rst_htrans", 32'(htrans_m),     32'(TRN_IDLE));
      check_eq("t5_rst_hsel",   32'(hsel_m),       32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("t5_mem_intact", mem[9], 32'h5555_5555);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
